// File: rtl/store_write_buffer.sv
// store_write_buffer
// Places right-justified store data into little-endian byte lanes, builds the
// byte-enable mask, queues accepted stores in a DEPTH-entry FIFO and drains
// them to data memory over a req/ack handshake. All memory-side outputs and
// status flags are registered.
// Optional build macro: STORE_BUF_COALESCE_EN lets an aligned store that hits
// the youngest queued word (when that entry is not the presented head) merge
// into it instead of allocating a new entry.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [5:0]    st_opcode,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    output logic          st_misaligned,
    output logic          mem_req,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WA = AW - 2;

    localparam logic [5:0]    OP_SB    = 6'b101000;
    localparam logic [5:0]    OP_SH    = 6'b101001;
    localparam logic [5:0]    OP_SW    = 6'b101011;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);

    typedef struct packed {
        logic        ok;
        logic [3:0]  be;
        logic [31:0] data;
    } lane_t;

    // Lane placement for one store: ok=0 marks a misaligned or non-store opcode.
    function automatic lane_t place_lanes(input logic [5:0]  op,
                                          input logic [1:0]  a,
                                          input logic [31:0] d);
        lane_t r;
        r = '0;
        case (op)
            OP_SB: begin
                r.ok   = 1'b1;
                r.be   = 4'b0001 << a;
                r.data = {24'h000000, d[7:0]} << {a, 3'b000};
            end
            OP_SH: begin
                if (a == 2'b00) begin
                    r.ok   = 1'b1;
                    r.be   = 4'b0011;
                    r.data = {16'h0000, d[15:0]};
                end else if (a == 2'b10) begin
                    r.ok   = 1'b1;
                    r.be   = 4'b1100;
                    r.data = {d[15:0], 16'h0000};
                end else begin
                    r = '0;
                end
            end
            OP_SW: begin
                if (a == 2'b00) begin
                    r.ok   = 1'b1;
                    r.be   = 4'b1111;
                    r.data = d;
                end else begin
                    r = '0;
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Byte-wise merge: lanes enabled in new_be take the new data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                                input logic [31:0] new_d,
                                                input logic [3:0]  new_be);
        logic [31:0] r;
        r = old_d;
        for (int i = 0; i < 4; i++) begin
            if (new_be[i]) begin
                r[8*i +: 8] = new_d[8*i +: 8];
            end else begin
                r[8*i +: 8] = old_d[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Entry storage
    logic [WA-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];

    // Control and presented-head registers
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          ready_r;
    logic          empty_r;
    logic          req_r;
    logic          mis_r;
    logic [WA-1:0] head_addr_r;
    logic [31:0]   head_data_r;
    logic [3:0]    head_be_r;

    // Next-state signals
    lane_t         lane_s;
    logic          offer_s;
    logic          accept_s;
    logic          reject_s;
    logic          pop_s;
    logic          merge_s;
    logic          alloc_s;
    logic [WA-1:0] st_word_s;
    logic [PW-1:0] young_s;
    logic [PW-1:0] wr_idx_s;
    logic [31:0]   wr_data_s;
    logic [3:0]    wr_be_s;
    logic [CW-1:0] count_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [WA-1:0] head_addr_s;
    logic [31:0]   head_data_s;
    logic [3:0]    head_be_s;

    // Accept/reject decision, push/pop bookkeeping and next presented head.
    always_comb begin
        lane_s    = place_lanes(st_opcode, st_addr[1:0], st_data);
        offer_s   = st_valid && ready_r;
        accept_s  = offer_s && lane_s.ok;
        reject_s  = offer_s && !lane_s.ok;
        pop_s     = req_r && mem_ack;
        st_word_s = st_addr[AW-1:2];
        young_s   = wr_ptr_r - PW'(1);
`ifdef STORE_BUF_COALESCE_EN
        merge_s   = accept_s && (count_r >= CNT_TWO) && (addr_q[young_s] == st_word_s);
`else
        merge_s   = 1'b0;
`endif
        alloc_s   = accept_s && !merge_s;

        if (merge_s) begin
            wr_idx_s  = young_s;
            wr_be_s   = be_q[young_s] | lane_s.be;
            wr_data_s = merge_bytes(data_q[young_s], lane_s.data, lane_s.be);
        end else begin
            wr_idx_s  = wr_ptr_r;
            wr_be_s   = lane_s.be;
            wr_data_s = lane_s.data;
        end

        case ({alloc_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        if (alloc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        // The slot written this cycle may be the one presented next; forward it.
        if (count_nxt_s == '0) begin
            head_addr_s = '0;
            head_data_s = 32'h0000_0000;
            head_be_s   = 4'b0000;
        end else if (accept_s && (wr_idx_s == rd_ptr_nxt_s)) begin
            head_addr_s = st_word_s;
            head_data_s = wr_data_s;
            head_be_s   = wr_be_s;
        end else begin
            head_addr_s = addr_q[rd_ptr_nxt_s];
            head_data_s = data_q[rd_ptr_nxt_s];
            head_be_s   = be_q[rd_ptr_nxt_s];
        end
    end

    // Pointers, occupancy, status flags and the registered memory-side head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            ready_r     <= 1'b1;
            empty_r     <= 1'b1;
            req_r       <= 1'b0;
            mis_r       <= 1'b0;
            head_addr_r <= '0;
            head_data_r <= 32'h0000_0000;
            head_be_r   <= 4'b0000;
        end else begin
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            count_r     <= count_nxt_s;
            ready_r     <= (count_nxt_s < CNT_FULL);
            empty_r     <= (count_nxt_s == '0);
            req_r       <= (count_nxt_s != '0);
            mis_r       <= reject_s;
            head_addr_r <= head_addr_s;
            head_data_r <= head_data_s;
            head_be_r   <= head_be_s;
        end
    end

    // Entry storage: allocation fills a fresh slot, coalescing rewrites the youngest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= 32'h0000_0000;
                be_q[i]   <= 4'b0000;
            end
        end else if (accept_s) begin
            addr_q[wr_idx_s] <= st_word_s;
            data_q[wr_idx_s] <= wr_data_s;
            be_q[wr_idx_s]   <= wr_be_s;
        end
    end

    assign st_ready      = ready_r;
    assign st_misaligned = mis_r;
    assign mem_req       = req_r;
    assign mem_addr      = head_addr_r;
    assign mem_wdata     = head_data_r;
    assign mem_be        = head_be_r;
    assign empty         = empty_r;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: lane-placement vector table,
// hand-written multi-cycle sequences and a randomized run against a queue model.
`timescale 1ns/1ps
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SWL = 6'b101010;

    logic          clk;
    logic          reset_n;
    logic          st_valid;
    logic          st_ready;
    logic [5:0]    st_opcode;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic          st_misaligned;
    logic          mem_req;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack;
    logic          empty;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ok;
        logic [3:0]  be;
        logic [31:0] wdata;
    } vec_t;

    wr_t  got_q[$];
    wr_t  mq[$];
    vec_t vt[14];

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_opcode(st_opcode),
        .st_addr(st_addr), .st_data(st_data), .st_misaligned(st_misaligned),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed memory handshake (inputs are stable at the negedge).
    always @(negedge clk) begin : mon
        wr_t w;
        if (reset_n === 1'b1 && mem_req === 1'b1 && mem_ack === 1'b1) begin
            w.addr = mem_addr;
            w.data = mem_wdata;
            w.be   = mem_be;
            got_q.push_back(w);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_opcode = op;
        st_addr   = a;
        st_data   = d;
    endtask

    // Specification lane rules, written with plain arithmetic.
    function automatic bit model_place(input logic [5:0] op, input logic [31:0] addr,
                                       input logic [31:0] d, output wr_t w);
        int a;
        a = int'(addr[1:0]);
        w.addr = addr[31:2];
        if (op == OP_SB) begin
            w.be = 4'(1 << a); w.data = (d & 32'h0000_00FF) << (8 * a); return 1'b1;
        end
        if (op == OP_SH && (a % 2) == 0) begin
            w.be = 4'(3 << a); w.data = (d & 32'h0000_FFFF) << (8 * a); return 1'b1;
        end
        if (op == OP_SW && a == 0) begin
            w.be = 4'hF; w.data = d; return 1'b1;
        end
        w.be = 4'h0; w.data = 32'h0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic do_reset();
        reset_n  = 1'b0;
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin : main
        wr_t w;
        bit  ok;
        bit  acc;
        bit  exp_mis;
        int  pre;
        int  r;

        reset_n = 1'b0; st_valid = 1'b0; st_opcode = 6'h00;
        st_addr = 32'h0; st_data = 32'h0; mem_ack = 1'b0;
        repeat (2) step();
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst empty", empty, 1'b1);
        chk("rst st_ready", st_ready, 1'b1);
        chk("rst misaligned", st_misaligned, 1'b0);
        chk("rst mem_be", mem_be, 4'h0);
        chk("rst mem_addr", mem_addr, 30'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        reset_n = 1'b1;
        step();
        chk("post-rst empty", empty, 1'b1);

        // ---- table-driven lane placement, mem_ack tied 1 ----
        vt[0]  = '{OP_SB,  32'h1003, 32'h0000_00AB, 1'b1, 4'b1000, 32'hAB00_0000};
        vt[1]  = '{OP_SB,  32'h1000, 32'hFFFF_FF12, 1'b1, 4'b0001, 32'h0000_0012};
        vt[2]  = '{OP_SB,  32'h1001, 32'h0000_0034, 1'b1, 4'b0010, 32'h0000_3400};
        vt[3]  = '{OP_SB,  32'h1002, 32'h0000_0056, 1'b1, 4'b0100, 32'h0056_0000};
        vt[4]  = '{OP_SH,  32'h2000, 32'hAAAA_1234, 1'b1, 4'b0011, 32'h0000_1234};
        vt[5]  = '{OP_SH,  32'h2002, 32'h0000_BEEF, 1'b1, 4'b1100, 32'hBEEF_0000};
        vt[6]  = '{OP_SH,  32'h2001, 32'h0000_1111, 1'b0, 4'b0000, 32'h0};
        vt[7]  = '{OP_SH,  32'h2003, 32'h0000_2222, 1'b0, 4'b0000, 32'h0};
        vt[8]  = '{OP_SW,  32'h2004, 32'h1234_5678, 1'b1, 4'b1111, 32'h1234_5678};
        vt[9]  = '{OP_SW,  32'h3001, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0};
        vt[10] = '{OP_SW,  32'h3002, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0};
        vt[11] = '{OP_SW,  32'h3003, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0};
        vt[12] = '{OP_LW,  32'h4000, 32'h0BAD_F00D, 1'b0, 4'b0000, 32'h0};
        vt[13] = '{OP_SWL, 32'h4000, 32'h0BAD_F00D, 1'b0, 4'b0000, 32'h0};

        mem_ack = 1'b1;
        foreach (vt[i]) begin
            drive(vt[i].op, vt[i].addr, vt[i].data);
            chk($sformatf("vec%0d st_ready", i), st_ready, 1'b1);
            step();
            st_valid = 1'b0;
            chk($sformatf("vec%0d mem_req", i), mem_req, vt[i].ok);
            chk($sformatf("vec%0d empty", i), empty, !vt[i].ok);
            chk($sformatf("vec%0d misaligned", i), st_misaligned, !vt[i].ok);
            if (vt[i].ok) begin
                chk($sformatf("vec%0d mem_be", i), mem_be, vt[i].be);
                chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vt[i].wdata);
                chk($sformatf("vec%0d mem_addr", i), mem_addr, vt[i].addr[31:2]);
            end
            step();
            chk($sformatf("vec%0d drained empty", i), empty, 1'b1);
            chk($sformatf("vec%0d drained req", i), mem_req, 1'b0);
            chk($sformatf("vec%0d mis pulse end", i), st_misaligned, 1'b0);
        end

        // ---- head stable under back-pressure ----
        mem_ack = 1'b0;
        drive(OP_SH, 32'h2002, 32'h0000_BEEF);
        step();
        drive(OP_SW, 32'h2004, 32'h1234_5678);
        chk("bp head be", mem_be, 4'b1100);
        chk("bp head wdata", mem_wdata, 32'hBEEF_0000);
        step();
        st_valid = 1'b0;
        chk("bp stable be", mem_be, 4'b1100);
        chk("bp stable wdata", mem_wdata, 32'hBEEF_0000);
        chk("bp stable addr", mem_addr, 30'h800);
        step();
        chk("bp stable2 wdata", mem_wdata, 32'hBEEF_0000);
        mem_ack = 1'b1;
        step();
        chk("bp next be", mem_be, 4'b1111);
        chk("bp next wdata", mem_wdata, 32'h1234_5678);
        chk("bp next addr", mem_addr, 30'h801);
        step();
        chk("bp drained", empty, 1'b1);

        // ---- full FIFO, simultaneous ack and offer ----
        got_q.delete();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(OP_SW, 32'h6000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            step();
        end
        chk("full st_ready", st_ready, 1'b0);
        chk("full mem_req", mem_req, 1'b1);
        chk("full head addr", mem_addr, 30'h1800);
        drive(OP_SW, 32'h6010, 32'hA000_0004);
        mem_ack = 1'b1;
        step();
        chk("full ack ready", st_ready, 1'b1);
        chk("full ack pops", got_q.size(), 1);
        chk("full ack no mis", st_misaligned, 1'b0);
        chk("full ack head", mem_addr, 30'h1801);
        mem_ack = 1'b0;
        step();
        chk("full refill ready", st_ready, 1'b0);
        st_valid = 1'b0;
        mem_ack = 1'b1;
        repeat (4) step();
        chk("full drained", empty, 1'b1);
        chk("full stream len", got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("full order addr%0d", i), got_q[i].addr, 30'h1800 + 30'(i));
                chk($sformatf("full order data%0d", i), got_q[i].data, 32'hA000_0000 + 32'(i));
                chk($sformatf("full order be%0d", i), got_q[i].be, 4'hF);
            end
        end

`ifdef STORE_BUF_COALESCE_EN
        // ---- coalescing into the youngest entry ----
        got_q.delete();
        mem_ack = 1'b0;
        drive(OP_SW, 32'h7000, 32'h1111_1111); step();
        drive(OP_SW, 32'h7004, 32'h2222_2222); step();
        drive(OP_SB, 32'h5000, 32'h0000_0011); step();
        drive(OP_SB, 32'h5001, 32'h0000_0022); step();
        st_valid = 1'b0;
        mem_ack = 1'b1;
        repeat (4) step();
        chk("coal stream len", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("coal be", got_q[2].be, 4'b0011);
            chk("coal wdata", got_q[2].data, 32'h0000_2211);
            chk("coal addr", got_q[2].addr, 30'h1400);
        end
`endif

        // ---- reset mid-drain ----
        got_q.delete();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(OP_SW, 32'h8000 + 32'(4 * i), 32'h5555_0000 + 32'(i));
            step();
        end
        st_valid = 1'b0;
        chk("mid req before rst", mem_req, 1'b1);
        mem_ack = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid rst req", mem_req, 1'b0);
        chk("mid rst empty", empty, 1'b1);
        chk("mid rst be", mem_be, 4'h0);
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("mid no writes", got_q.size(), 0);
        chk("mid be quiet", mem_be, 4'h0);
        chk("mid empty after", empty, 1'b1);

        // ---- randomized run against a queue model ----
        do_reset();
        mq.delete();
        exp_mis = 1'b0;
        for (int c = 0; c < 800; c++) begin
            chk("rnd st_ready", st_ready, mq.size() < DEPTH);
            chk("rnd mem_req", mem_req, mq.size() > 0);
            chk("rnd empty", empty, mq.size() == 0);
            chk("rnd misaligned", st_misaligned, exp_mis);
            if (mq.size() > 0) begin
                chk("rnd mem_addr", mem_addr, mq[0].addr);
                chk("rnd mem_wdata", mem_wdata, mq[0].data);
                chk("rnd mem_be", mem_be, mq[0].be);
            end

            st_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 3)      st_opcode = OP_SB;
            else if (r < 6) st_opcode = OP_SH;
            else if (r < 9) st_opcode = OP_SW;
            else            st_opcode = 6'($urandom_range(0, 63));
            st_addr = 32'h9000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            st_data = $urandom();
            mem_ack = ($urandom_range(0, 2) != 0);

            ok      = model_place(st_opcode, st_addr, st_data, w);
            pre     = mq.size();
            acc     = st_valid && (pre < DEPTH) && ok;
            exp_mis = st_valid && (pre < DEPTH) && !ok;
            if (acc) begin
`ifdef STORE_BUF_COALESCE_EN
                if (pre >= 2 && mq[pre-1].addr == w.addr) begin
                    mq[pre-1].data = (mq[pre-1].data & ~be_mask(w.be)) | (w.data & be_mask(w.be));
                    mq[pre-1].be   = mq[pre-1].be | w.be;
                end else begin
                    mq.push_back(w);
                end
`else
                mq.push_back(w);
`endif
            end
            if (pre > 0 && mem_ack) begin
                void'(mq.pop_front());
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
